// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD frame assembler.
package bcd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_frame_assembler_if.sv
// Byte-in / frame-out bus of the BCD frame assembler.
interface bcd_frame_assembler_if #(
  parameter int NIBBLES = 4
) ();

  logic                   in_valid;
  logic [7:0]             in_byte;
  logic [4*NIBBLES-1:0]   data_lo;
  logic [4*NIBBLES-1:0]   data_hi;
  logic                   out_valid;
  logic                   frame_err;
  logic                   bcd_err;
  logic [15:0]            frame_count;

  modport master (
    output in_valid, in_byte,
    input  data_lo, data_hi, out_valid, frame_err, bcd_err, frame_count
  );

  modport slave (
    input  in_valid, in_byte,
    output data_lo, data_hi, out_valid, frame_err, bcd_err, frame_count
  );

endinterface

// File: rtl/bcd_timeout_counter.sv
// Inter-byte idle counter; expired is asserted on the idle cycle that makes
// the count reach TIMEOUT_CYCLES, so a byte in that same cycle still wins.
module bcd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [CW-1:0] r_count;

  assign expired = enable && !clear && (r_count == LAST_COUNT);

  // idle-cycle count, held at zero outside a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (!enable || clear || expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/bcd_frame_assembler.sv
// Assembles NIBBLES received bytes into two packed BCD words and publishes
// them atomically; partial frames are dropped on timeout or reset.
module bcd_frame_assembler
  import bcd_pkg::*;
#(
  parameter int NIBBLES        = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CHECK_BCD      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_frame_assembler_if.slave  bus
);

  localparam int IDXW = $clog2(NIBBLES) + 1;
  localparam int DW   = 4 * NIBBLES;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t            r_state;
  logic [IDXW-1:0]   r_idx;
  logic [DW-1:0]     r_shadow_lo;
  logic [DW-1:0]     r_shadow_hi;
  logic              r_bad;
  logic [DW-1:0]     r_data_lo;
  logic [DW-1:0]     r_data_hi;
  logic              r_out_valid;
  logic              r_frame_err;
  logic              r_bcd_err;
  logic [15:0]       r_frame_count;

  logic [IDXW-1:0]   w_pos;
  logic [DW-1:0]     w_merge_lo;
  logic [DW-1:0]     w_merge_hi;
  logic              w_byte_bad;
  logic              w_frame_bad;
  logic              w_last;
  logic              w_complete;
  logic              w_enable;
  logic              w_expired;

  assign w_enable = (r_state == ST_COLLECT);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      bcd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_enable),
        .clear   (bus.in_valid),
        .expired (w_expired)
      );
    end else begin : g_no_timeout
      assign w_expired = 1'b0;
    end
  endgenerate

  // shadow words with the incoming byte dropped into its digit slot;
  // a new frame starts from a clean shadow
  always_comb begin
    w_pos      = (r_state == ST_IDLE) ? '0 : r_idx;
    w_merge_lo = (r_state == ST_IDLE) ? '0 : r_shadow_lo;
    w_merge_hi = (r_state == ST_IDLE) ? '0 : r_shadow_hi;
    for (int k = 0; k < NIBBLES; k++) begin
      if (IDXW'(k) == w_pos) begin
        w_merge_lo[4*k +: 4] = bus.in_byte[3:0];
        w_merge_hi[4*k +: 4] = bus.in_byte[7:4];
      end else begin
        w_merge_lo[4*k +: 4] = w_merge_lo[4*k +: 4];
        w_merge_hi[4*k +: 4] = w_merge_hi[4*k +: 4];
      end
    end
    w_byte_bad  = (CHECK_BCD != 0) && (!is_bcd(bus.in_byte[3:0]) || !is_bcd(bus.in_byte[7:4]));
    w_frame_bad = w_byte_bad || ((r_state == ST_COLLECT) && r_bad);
    w_last      = (r_state == ST_IDLE) ? (NIBBLES == 1) : (r_idx == LAST_IDX);
    w_complete  = bus.in_valid && w_last;
  end

  // frame FSM, shadow capture, atomic publish and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_shadow_lo   <= '0;
      r_shadow_hi   <= '0;
      r_bad         <= 1'b0;
      r_data_lo     <= '0;
      r_data_hi     <= '0;
      r_out_valid   <= 1'b0;
      r_frame_err   <= 1'b0;
      r_bcd_err     <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_bcd_err   <= 1'b0;
      if (w_complete) begin
        r_state     <= ST_IDLE;
        r_idx       <= '0;
        r_shadow_lo <= '0;
        r_shadow_hi <= '0;
        r_bad       <= 1'b0;
        if (w_frame_bad) begin
          r_bcd_err <= 1'b1;
        end else begin
          r_data_lo     <= w_merge_lo;
          r_data_hi     <= w_merge_hi;
          r_frame_count <= r_frame_count + 16'd1;
          r_out_valid   <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.in_valid) begin
              r_shadow_lo <= w_merge_lo;
              r_shadow_hi <= w_merge_hi;
              r_idx       <= IDXW'(1);
              r_bad       <= w_byte_bad;
              r_state     <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (bus.in_valid) begin
              r_shadow_lo <= w_merge_lo;
              r_shadow_hi <= w_merge_hi;
              r_idx       <= r_idx + IDXW'(1);
              r_bad       <= w_frame_bad;
            end else if (w_expired) begin
              r_shadow_lo <= '0;
              r_shadow_hi <= '0;
              r_idx       <= '0;
              r_bad       <= 1'b0;
              r_state     <= ST_IDLE;
              r_frame_err <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_bad   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_lo     = r_data_lo;
  assign bus.data_hi     = r_data_hi;
  assign bus.out_valid   = r_out_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.bcd_err     = r_bcd_err;
  assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_bcd_frame_assembler.sv
// Bench for bcd_frame_assembler: a 4-digit/timeout-10 instance and a
// 1-digit/no-timeout instance share one byte stream and a frame-level model.
module tb_bcd_frame_assembler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_frame_assembler_if #(.NIBBLES(4)) bus4 ();
  bcd_frame_assembler_if #(.NIBBLES(1)) bus1 ();

  bcd_frame_assembler #(
    .NIBBLES(4), .TIMEOUT_CYCLES(10), .CHECK_BCD(1)
  ) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  bcd_frame_assembler #(
    .NIBBLES(1), .TIMEOUT_CYCLES(0), .CHECK_BCD(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int total = 0;
  int bad   = 0;

  // reference model state: bytes of the pending frame and idle gap length
  int          pend[$];
  int          gap = 0;
  logic [15:0] e_lo4 = 16'd0, e_hi4 = 16'd0, e_cnt4 = 16'd0;
  bit          e_ov4, e_fe4, e_be4;
  logic [3:0]  e_lo1 = 4'd0, e_hi1 = 4'd0;
  logic [15:0] e_cnt1 = 16'd0;
  bit          e_ov1, e_be1;

  function automatic bit digits_ok(int b);
    return ((b % 16) <= 9) && ((b / 16) <= 9);
  endfunction

  task automatic model(bit r, bit v, int b);
    int lo, hi;
    bit ok;
    e_ov4 = 1'b0; e_fe4 = 1'b0; e_be4 = 1'b0; e_ov1 = 1'b0; e_be1 = 1'b0;
    if (r) begin
      e_lo4 = 16'd0; e_hi4 = 16'd0; e_cnt4 = 16'd0;
      e_lo1 = 4'd0; e_hi1 = 4'd0; e_cnt1 = 16'd0;
      pend.delete();
      gap = 0;
    end else if (v) begin
      if (digits_ok(b)) begin
        e_lo1 = 4'(b % 16); e_hi1 = 4'(b / 16); e_cnt1 = e_cnt1 + 16'd1; e_ov1 = 1'b1;
      end else begin
        e_be1 = 1'b1;
      end
      pend.push_back(b);
      gap = 0;
      if (pend.size() == 4) begin
        ok = 1'b1; lo = 0; hi = 0;
        for (int k = 3; k >= 0; k--) begin
          ok = ok && digits_ok(pend[k]);
          lo = lo * 16 + (pend[k] % 16);
          hi = hi * 16 + (pend[k] / 16);
        end
        if (ok) begin
          e_lo4 = 16'(lo); e_hi4 = 16'(hi); e_cnt4 = e_cnt4 + 16'd1; e_ov4 = 1'b1;
        end else begin
          e_be4 = 1'b1;
        end
        pend.delete();
      end
    end else if (pend.size() > 0) begin
      gap++;
      if (gap == 10) begin
        e_fe4 = 1'b1;
        pend.delete();
        gap = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(bit r, bit v, logic [7:0] b);
    rst = r;
    bus4.in_valid = v; bus4.in_byte = b;
    bus1.in_valid = v; bus1.in_byte = b;
    @(posedge clk);
    model(r, v, int'(b));
    #1;
    chk("out_valid4",   32'(bus4.out_valid),   32'(e_ov4));
    chk("frame_err4",   32'(bus4.frame_err),   32'(e_fe4));
    chk("bcd_err4",     32'(bus4.bcd_err),     32'(e_be4));
    chk("data_lo4",     32'(bus4.data_lo),     32'(e_lo4));
    chk("data_hi4",     32'(bus4.data_hi),     32'(e_hi4));
    chk("count4",       32'(bus4.frame_count), 32'(e_cnt4));
    chk("out_valid1",   32'(bus1.out_valid),   32'(e_ov1));
    chk("frame_err1",   32'(bus1.frame_err),   32'd0);
    chk("bcd_err1",     32'(bus1.bcd_err),     32'(e_be1));
    chk("data_lo1",     32'(bus1.data_lo),     32'(e_lo1));
    chk("data_hi1",     32'(bus1.data_hi),     32'(e_hi1));
    chk("count1",       32'(bus1.frame_count), 32'(e_cnt1));
  endtask

  task automatic send(logic [7:0] b);
    cycle(1'b0, 1'b1, b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] rb;
    bus4.in_valid = 1'b0; bus4.in_byte = 8'h00;
    bus1.in_valid = 1'b0; bus1.in_byte = 8'h00;

    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    idle(2);

    // basic frame
    send(8'h21); send(8'h43); send(8'h65); send(8'h87);
    chk("basic_lo", 32'(bus4.data_lo), 32'h7531);
    chk("basic_hi", 32'(bus4.data_hi), 32'h8642);
    chk("basic_cnt", 32'(bus4.frame_count), 32'd1);

    // back-to-back frame with no gap
    for (int i = 0; i < 4; i++) send(8'h99);
    chk("b2b_lo", 32'(bus4.data_lo), 32'h9999);
    chk("b2b_cnt", 32'(bus4.frame_count), 32'd2);
    idle(1);

    // bad digit in byte 1
    send(8'h21); send(8'h4A); send(8'h65); send(8'h87);
    chk("baddig_bcd_err", 32'(bus4.bcd_err), 32'd1);
    chk("baddig_hold_lo", 32'(bus4.data_lo), 32'h9999);
    chk("baddig_cnt", 32'(bus4.frame_count), 32'd2);

    // timeout after two bytes, then a fresh frame
    send(8'h11); send(8'h22);
    idle(9);
    chk("to_not_yet", 32'(bus4.frame_err), 32'd0);
    idle(1);
    chk("to_frame_err", 32'(bus4.frame_err), 32'd1);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("to_after_lo", 32'(bus4.data_lo), 32'h8642);
    chk("to_after_hi", 32'(bus4.data_hi), 32'h7531);

    // nine idle cycles between bytes is still one frame
    send(8'h13); idle(9); send(8'h24); idle(9); send(8'h35); idle(9); send(8'h46);
    chk("gap9_lo", 32'(bus4.data_lo), 32'h6543);
    chk("gap9_hi", 32'(bus4.data_hi), 32'h4321);
    chk("gap9_cnt", 32'(bus4.frame_count), 32'd4);

    // reset mid-frame
    send(8'h01); send(8'h02); send(8'h03);
    cycle(1'b1, 1'b0, 8'h00);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    chk("rst_lo", 32'(bus4.data_lo), 32'h8765);
    chk("rst_cnt", 32'(bus4.frame_count), 32'd1);
    idle(12);

    // single-digit instance
    send(8'h53);
    chk("n1_lo", 32'(bus1.data_lo), 32'h3);
    chk("n1_hi", 32'(bus1.data_hi), 32'h5);
    chk("n1_ov", 32'(bus1.out_valid), 32'd1);

    // randomized traffic with gaps around the timeout and rare resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        cycle(1'b1, 1'b0, 8'h00);
      end else if ($urandom_range(0, 24) == 0) begin
        idle(int'($urandom_range(8, 11)));
      end else if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 11) == 0) begin
          rb = 8'($urandom_range(0, 255));
        end else begin
          rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
        send(rb);
      end else begin
        idle(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
